// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its neighbours: timing/pixel
// path, pixel-writer handshake and single-port RAM access.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              frame_start;
  logic              pix_req;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  frame_start, pix_req, wr_valid, wr_addr, wr_data, mem_rdata,
    output pix_valid, pix_data, underflow, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output frame_start, pix_req, wr_valid, wr_addr, wr_data, mem_rdata,
    input  pix_valid, pix_data, underflow, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer between raster-order scanout prefetch
// (show-ahead FIFO) and a pixel writer granted the idle RAM slots.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic            clk,
  input  logic            rst,
  vga_fb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  HALF      = CNT_W'(FIFO_DEPTH / 2);

  typedef enum logic [1:0] {IDLE = 2'd0, PREFETCH = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];

  logic [CNT_W-1:0]  level_s;
  logic              eligible_s, fetch_sel_s, fetch_s, grant_s;
  logic              push_s, pop_s, empty_s;

  // Level counts the in-flight read so the FIFO can never overflow.
  assign level_s    = count_q + {{PTR_W{1'b0}}, inflight_q};
  assign eligible_s = (level_s < FULL);
  assign empty_s    = (count_q == {CNT_W{1'b0}});

  // RAM slot arbitration: one grant per cycle.
  always_comb begin
    fetch_sel_s = 1'b0;
    grant_s     = 1'b0;
    case (state_q)
      IDLE, DONE: grant_s = bus.wr_valid;
      PREFETCH:   fetch_sel_s = eligible_s;
      RUN: begin
        if (eligible_s && (level_s < HALF)) begin
          fetch_sel_s = 1'b1;
        end else if (bus.wr_valid) begin
          grant_s = 1'b1;
        end else begin
          fetch_sel_s = eligible_s;
        end
      end
      default: begin
        fetch_sel_s = 1'b0;
        grant_s     = 1'b0;
      end
    endcase
  end

  // A fetch in the restart cycle would belong to the old frame, so it is held off.
  assign fetch_s = fetch_sel_s & ~bus.frame_start;
  assign push_s  = inflight_q & ~bus.frame_start;
  assign pop_s   = bus.pix_req & ~empty_s & ~bus.frame_start;

  assign bus.wr_ready  = grant_s;
  assign bus.mem_en    = fetch_s | grant_s;
  assign bus.mem_we    = grant_s;
  assign bus.mem_addr  = grant_s ? bus.wr_addr : fetch_addr_q;
  assign bus.mem_wdata = grant_s ? bus.wr_data : {DATA_W{1'b0}};
  assign bus.pix_valid = ~empty_s;
  assign bus.pix_data  = empty_s ? {DATA_W{1'b0}} : fifo_q[rd_ptr_q];
  assign bus.underflow = underflow_q;

  // Next state, fetch address and FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    inflight_d   = fetch_s;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    underflow_d  = underflow_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_d[i] = (push_s && (wr_ptr_q == PTR_W'(i))) ? bus.mem_rdata : fifo_q[i];
    end

    if (bus.frame_start) begin
      state_d      = PREFETCH;
      fetch_addr_d = {ADDR_W{1'b0}};
    end else if (fetch_s && (fetch_addr_q == LAST_ADDR)) begin
      state_d      = DONE;
      fetch_addr_d = fetch_addr_q;
    end else begin
      fetch_addr_d = fetch_s ? fetch_addr_q + 1'b1 : fetch_addr_q;
      state_d      = ((state_q == PREFETCH) && (count_q == FULL)) ? RUN : state_q;
    end

    if (bus.frame_start) begin
      count_d     = {CNT_W{1'b0}};
      rd_ptr_d    = {PTR_W{1'b0}};
      wr_ptr_d    = {PTR_W{1'b0}};
      underflow_d = 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      rd_ptr_d    = pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d    = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
      underflow_d = (bus.pix_req && empty_s) ? 1'b1 : underflow_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= {ADDR_W{1'b0}};
      inflight_q   <= 1'b0;
      count_q      <= {CNT_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      underflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      underflow_q  <= underflow_d;
      fifo_q       <= fifo_d;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 16x4 frame (last address 63)
// with a one-cycle-latency RAM model returning an address-derived pattern.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;
  localparam int H_ACT  = 16;
  localparam int V_ACT  = 4;
  localparam int NPIX   = H_ACT * V_ACT;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pix_of(input logic [ADDR_W-1:0] a);
    return {5'h15, a};
  endfunction

  // RAM model: read data valid exactly one cycle after the read.
  always @(posedge clk) begin
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? pix_of(bus.mem_addr) : 24'hBADBAD;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first cycle after a frame_start edge.
  task automatic prefetch_check(input string tag);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 8) begin
        chk({tag, "_rd_en"}, 64'(bus.mem_en), 64'd1);
        chk({tag, "_rd_we"}, 64'(bus.mem_we), 64'd0);
        chk({tag, "_rd_addr"}, 64'(bus.mem_addr), 64'(c));
      end else begin
        chk({tag, "_full_idle"}, 64'(bus.mem_en), 64'd0);
      end
      if (c < 2) begin
        chk({tag, "_pv_early"}, 64'(bus.pix_valid), 64'd0);
      end else if (c == 2) begin
        chk({tag, "_pv_lat2"}, 64'(bus.pix_valid), 64'd1);
        chk({tag, "_pd_first"}, 64'(bus.pix_data), 64'(pix_of(19'd0)));
      end
      @(negedge clk);
    end
    #1;
    chk({tag, "_state_run"}, 64'(dut.state_q), 64'd2);
  endtask

  initial begin
    int exp_addr;
    int n_fetch;
    int pop_idx;
    int last_addr;
    logic found;

    rst = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_req     = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_addr     = 19'd0;
    bus.wr_data     = 24'd0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("rst_pix_data", 64'(bus.pix_data), 64'd0);
    chk("rst_underflow", 64'(bus.underflow), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Prefetch from IDLE
    @(negedge clk);
    bus.frame_start = 1'b1;
    #1;
    chk("idle_no_fetch", 64'(bus.mem_en), 64'd0);
    @(negedge clk);
    bus.frame_start = 1'b0;
    prefetch_check("pre");

    // Contention: writer held while the FIFO drains from 8 to 3
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 19'h12345;
    bus.wr_data  = 24'hFF00FF;
    bus.pix_req  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("cont_head", 64'(bus.pix_data), 64'(pix_of(ADDR_W'(c))));
      chk("cont_grant", 64'(bus.wr_ready), 64'd1);
      if (c == 2) begin
        chk("cont_l6_we", 64'(bus.mem_we), 64'd1);
        chk("cont_l6_addr", 64'(bus.mem_addr), 64'h12345);
        chk("cont_l6_wdata", 64'(bus.mem_wdata), 64'hFF00FF);
      end
      @(negedge clk);
    end
    bus.pix_req = 1'b0;
    #1;
    chk("urgent_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("urgent_mem_en", 64'(bus.mem_en), 64'd1);
    chk("urgent_mem_we", 64'(bus.mem_we), 64'd0);
    chk("urgent_addr", 64'(bus.mem_addr), 64'd8);
    chk("urgent_head", 64'(bus.pix_data), 64'(pix_of(19'd5)));

    // Async reset with a read in flight
    @(negedge clk);
    bus.wr_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("arst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("arst_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("arst_pix_data", 64'(bus.pix_data), 64'd0);
    chk("arst_underflow", 64'(bus.underflow), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_idle_state", 64'(dut.state_q), 64'd0);
    chk("arst_idle_no_fetch", 64'(bus.mem_en), 64'd0);
    chk("arst_idle_pv", 64'(bus.pix_valid), 64'd0);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 19'h00ABC;
    bus.wr_data  = 24'h123456;
    #1;
    chk("idle_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("idle_wr_we", 64'(bus.mem_we), 64'd1);
    chk("idle_wr_addr", 64'(bus.mem_addr), 64'h00ABC);
    @(negedge clk);
    bus.wr_valid = 1'b0;

    // Underflow: sticky until the next frame_start
    bus.pix_req = 1'b1;
    #1;
    chk("uf_pix_data", 64'(bus.pix_data), 64'd0);
    chk("uf_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("uf_not_yet", 64'(bus.underflow), 64'd0);
    @(negedge clk);
    bus.pix_req = 1'b0;
    #1;
    chk("uf_set", 64'(bus.underflow), 64'd1);
    repeat (1000) @(negedge clk);
    #1;
    chk("uf_held", 64'(bus.underflow), 64'd1);
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    #1;
    chk("uf_cleared", 64'(bus.underflow), 64'd0);
    prefetch_check("pre2");

    // End of frame: continuous pops until every pixel of the frame is consumed
    exp_addr  = 8;
    n_fetch   = 8;
    pop_idx   = 0;
    last_addr = 7;
    for (int c = 0; c < 400 && pop_idx < NPIX; c++) begin
      bus.pix_req = 1'b1;
      #1;
      if (bus.mem_en && !bus.mem_we) begin
        chk("eof_seq_addr", 64'(bus.mem_addr), 64'(exp_addr));
        exp_addr++;
        n_fetch++;
        last_addr = int'(bus.mem_addr);
      end
      if (bus.pix_valid) begin
        chk("eof_pix", 64'(bus.pix_data), 64'(pix_of(ADDR_W'(pop_idx))));
        pop_idx++;
      end
      @(negedge clk);
    end
    bus.pix_req = 1'b0;
    #1;
    chk("eof_pops", 64'(pop_idx), 64'(NPIX));
    chk("eof_fetches", 64'(n_fetch), 64'(NPIX));
    chk("eof_last_addr", 64'(last_addr), 64'(NPIX - 1));
    chk("eof_state_done", 64'(dut.state_q), 64'd3);
    chk("eof_no_fetch", 64'(bus.mem_en), 64'd0);
    chk("eof_no_underflow", 64'(bus.underflow), 64'd0);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.wr_addr = ADDR_W'(19'h00200 + c);
      #1;
      chk("done_wr_ready", 64'(bus.wr_ready), 64'd1);
      chk("done_wr_addr", 64'(bus.mem_addr), 64'(19'h00200 + c));
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;

    // Restart the cycle after a read at address 40
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    prefetch_check("pre3");
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      bus.pix_req = 1'b1;
      #1;
      if (bus.mem_en && !bus.mem_we && (bus.mem_addr == 19'd40)) begin
        found = 1'b1;
      end
      @(negedge clk);
    end
    chk("rs_read40_seen", 64'(found), 64'd1);
    bus.pix_req     = 1'b0;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    prefetch_check("rs");
    for (int c = 0; c < 8; c++) begin
      bus.pix_req = 1'b1;
      #1;
      chk("rs_refill_data", 64'(bus.pix_data), 64'(pix_of(ADDR_W'(c))));
      @(negedge clk);
    end
    bus.pix_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
